// File: rtl/sram_1r1w_init_ext.sv
// Parametrised 1R1W SRAM with registered read data and a zero-init sequencer.
// Define SRAM_1R1W_FWD_EN to forward same-address write data into the read port.
module sram_1r1w_init_ext #(
    parameter int unsigned DEPTH    = 2048,
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned MASK_SEG = 1,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   R0_addr,
    input  logic                R0_en,
    output logic [WIDTH-1:0]    R0_data,
    input  logic [ADDR_W-1:0]   W0_addr,
    input  logic                W0_en,
    input  logic [WIDTH-1:0]    W0_data,
    input  logic [MASK_SEG-1:0] W0_mask,
    input  logic                init_req,
    output logic                init_done
);

    localparam int unsigned SEG_W = WIDTH / MASK_SEG;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    logic [WIDTH-1:0]  ram [DEPTH];

    logic [WIDTH-1:0]  bit_mask_c;
    logic              rd_ok_c;
    logic              wr_ok_c;
    logic              rd_fire_c;
    logic              wr_fire_c;
    logic [WIDTH-1:0]  rd_old_c;
    logic [WIDTH-1:0]  rd_val_c;
    logic [WIDTH-1:0]  wr_merge_c;

    // Expand per-segment mask bits to a per-bit mask
    for (genvar s = 0; s < MASK_SEG; s++) begin : g_mask
        assign bit_mask_c[s*SEG_W +: SEG_W] = {SEG_W{W0_mask[s]}};
    end

    // Next-state logic: sweep the array once, then serve traffic until re-init
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (init_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Access qualification; out-of-range addresses drop writes and read zero
    always_comb begin
        rd_ok_c    = 32'(R0_addr) < DEPTH;
        wr_ok_c    = 32'(W0_addr) < DEPTH;
        rd_fire_c  = (state_q == READY) && R0_en;
        wr_fire_c  = (state_q == READY) && W0_en && wr_ok_c;
        rd_old_c   = rd_ok_c ? ram[R0_addr] : '0;
        wr_merge_c = wr_ok_c ? ((ram[W0_addr] & ~bit_mask_c) | (W0_data & bit_mask_c)) : '0;
`ifdef SRAM_1R1W_FWD_EN
        rd_val_c   = (wr_fire_c && (W0_addr == R0_addr)) ? wr_merge_c : rd_old_c;
`else
        rd_val_c   = rd_old_c;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            init_done <= 1'b0;
            R0_data   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            init_done <= (state_d == READY);
            if (rd_fire_c) begin
                R0_data <= rd_val_c;
            end
        end
    end

    // Storage array carries no reset; INIT clears it one entry per cycle
    always_ff @(posedge clock) begin
        if (state_q == INIT) begin
            ram[cnt_q] <= '0;
        end else if (wr_fire_c) begin
            ram[W0_addr] <= wr_merge_c;
        end
    end

endmodule

// File: tb/tb_sram_1r1w_init_ext.sv
// Randomised scoreboard bench for sram_1r1w_init_ext (DEPTH=16, WIDTH=12, MASK_SEG=3).
module tb_sram_1r1w_init_ext;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned WIDTH    = 12;
    localparam int unsigned MASK_SEG = 3;
    localparam int unsigned ADDR_W   = 4;

    logic                clock;
    logic                reset_n;
    logic [ADDR_W-1:0]   R0_addr;
    logic                R0_en;
    logic [WIDTH-1:0]    R0_data;
    logic [ADDR_W-1:0]   W0_addr;
    logic                W0_en;
    logic [WIDTH-1:0]    W0_data;
    logic [MASK_SEG-1:0] W0_mask;
    logic                init_req;
    logic                init_done;

    sram_1r1w_init_ext #(
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .MASK_SEG(MASK_SEG)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .R0_addr  (R0_addr),
        .R0_en    (R0_en),
        .R0_data  (R0_data),
        .W0_addr  (W0_addr),
        .W0_en    (W0_en),
        .W0_data  (W0_data),
        .W0_mask  (W0_mask),
        .init_req (init_req),
        .init_done(init_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [WIDTH-1:0] rd;
        logic             done;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: array contents, read register, and init cycles remaining
    logic [WIDTH-1:0] ram_m [DEPTH];
    logic [WIDTH-1:0] rdata_m;
    bit               ready_m;
    int               left_m;

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                               input logic [WIDTH-1:0] data,
                                               input logic [MASK_SEG-1:0] mask);
        logic [WIDTH-1:0] r;
        r = old;
        for (int s = 0; s < MASK_SEG; s++) begin
            if (mask[s]) r[s*4 +: 4] = data[s*4 +: 4];
        end
        return r;
    endfunction

    task automatic idle_inputs();
        R0_en = 1'b0; R0_addr = '0;
        W0_en = 1'b0; W0_addr = '0; W0_data = '0; W0_mask = '0;
        init_req = 1'b0;
    endtask

    // Advance the model by one edge with the current inputs, queue the expectation, clock it
    task automatic step();
        logic [WIDTH-1:0] old_v;
        logic [WIDTH-1:0] new_v;
        if (ready_m) begin
            old_v = ram_m[R0_addr];
            new_v = merge(ram_m[W0_addr], W0_data, W0_mask);
            if (R0_en) rdata_m = old_v;
`ifdef SRAM_1R1W_FWD_EN
            if (R0_en && W0_en && (R0_addr == W0_addr)) rdata_m = new_v;
`endif
            if (W0_en) ram_m[W0_addr] = new_v;
            if (init_req) begin
                ready_m = 1'b0;
                left_m  = DEPTH;
            end
        end else begin
            left_m--;
            if (left_m == 0) begin
                ready_m = 1'b1;
                for (int i = 0; i < DEPTH; i++) ram_m[i] = '0;
            end
        end
        q.push_back({rdata_m, ready_m});
        @(posedge clock);
        #1;
    endtask

    task automatic op(input bit re, input int ra, input bit we, input int wa,
                      input logic [WIDTH-1:0] wd, input logic [MASK_SEG-1:0] wm, input bit ir);
        R0_en = re; R0_addr = ADDR_W'(ra);
        W0_en = we; W0_addr = ADDR_W'(wa); W0_data = wd; W0_mask = wm;
        init_req = ir;
        step();
        idle_inputs();
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        idle_inputs();
        ready_m = 1'b0;
        left_m  = DEPTH;
        rdata_m = '0;
        repeat (n) begin
            q.push_back({rdata_m, 1'b0});
            @(posedge clock);
            #1;
        end
        reset_n = 1'b1;
    endtask

    // Monitor: output is presented every cycle; compare away from the active edge
    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (R0_data !== e.rd) begin
                bad++;
                $display("FAIL rdata t=%0t got=%h exp=%h", $time, R0_data, e.rd);
            end
            total++;
            if (init_done !== e.done) begin
                bad++;
                $display("FAIL init_done t=%0t got=%b exp=%b", $time, init_done, e.done);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        rdata_m = '0;
        ready_m = 1'b0;
        left_m  = DEPTH;

        do_reset(3);
        repeat (DEPTH) op(0, 0, 0, 0, '0, '0, 0);
        for (int a = 0; a < DEPTH; a++) op(1, a, 0, 0, '0, '0, 0);

        // Basic write, read, then hold across a later write
        op(0, 0, 1, 5, 12'hABC, 3'b111, 0);
        op(1, 5, 0, 0, '0, '0, 0);
        op(0, 0, 1, 5, 12'h123, 3'b111, 0);
        op(0, 0, 0, 0, '0, '0, 0);

        // Segment mask
        op(0, 0, 1, 2, 12'hFFF, 3'b111, 0);
        op(0, 0, 1, 2, 12'h000, 3'b010, 0);
        op(1, 2, 0, 0, '0, '0, 0);
        op(0, 0, 1, 3, 12'h456, 3'b000, 0);
        op(1, 3, 0, 0, '0, '0, 0);

        // Same-address read/write collision
        op(0, 0, 1, 7, 12'h111, 3'b111, 0);
        op(1, 7, 1, 7, 12'h222, 3'b111, 0);
        op(1, 7, 0, 0, '0, '0, 0);
        op(1, 7, 1, 7, 12'h999, 3'b101, 0);
        op(1, 7, 0, 0, '0, '0, 0);

        // Random traffic with occasional re-init
        for (int i = 0; i < 400; i++) begin
            op(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
               WIDTH'($urandom), MASK_SEG'($urandom),
               ($urandom_range(0, 59) == 0));
        end
        for (int i = 0; i < DEPTH && !ready_m; i++) op(0, 0, 0, 0, '0, '0, 0);

        // Re-init request with traffic on the same cycle and reads during INIT
        op(0, 0, 1, 9, 12'h5A5, 3'b111, 0);
        op(1, 9, 1, 4, 12'h777, 3'b111, 1);
        for (int i = 0; i < DEPTH; i++) op(1, int'($urandom_range(0, DEPTH-1)), 1, i, 12'hFFF, 3'b111, 0);
        for (int a = 0; a < DEPTH; a++) op(1, a, 0, 0, '0, '0, 0);

        // Reset in the middle of INIT restarts the sweep
        op(0, 0, 1, 1, 12'h3C3, 3'b111, 0);
        op(1, 1, 0, 0, '0, '0, 1);
        repeat (8) op(1, 1, 0, 0, '0, '0, 0);
        do_reset(2);
        for (int i = 0; i < DEPTH + 2; i++) op(1, int'($urandom_range(0, DEPTH-1)), 0, 0, '0, '0, 0);
        for (int a = 0; a < DEPTH; a++) op(1, a, 0, 0, '0, '0, 0);

        @(negedge clock);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
